// File: rtl/io_pkg.sv
// Shared definitions for the core's I/O bus peripherals.
// Holds bus widths and the GPIO register offset map.
package io_pkg;

  localparam int IO_ADDR_W = 6;
  localparam int IO_DATA_W = 8;

  localparam logic [3:0] GPIO_DIR      = 4'd0;
  localparam logic [3:0] GPIO_OUT      = 4'd1;
  localparam logic [3:0] GPIO_OUTSET   = 4'd2;
  localparam logic [3:0] GPIO_OUTCLR   = 4'd3;
  localparam logic [3:0] GPIO_OUTTGL   = 4'd4;
  localparam logic [3:0] GPIO_IN       = 4'd5;
  localparam logic [3:0] GPIO_INTMASK  = 4'd6;
  localparam logic [3:0] GPIO_INTFLAGS = 4'd7;
  localparam logic [3:0] GPIO_ISC      = 4'd8;

endpackage

// File: rtl/io_sync_edge.sv
// Multi-stage synchroniser for asynchronous pad inputs, plus a one-cycle
// history flop so callers get rising/falling edge pulses on the clean signal.
module io_sync_edge #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
      prev <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign s    = chain[STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;

endmodule

// File: rtl/io_gpio_port.sv
// GPIO peripheral on the 6-bit I/O bus: direction/output registers with
// set/clear/toggle strobes, synchronised inputs and edge interrupt flags.
module io_gpio_port
  import io_pkg::*;
#(
  parameter int                   PORT_WIDTH  = 8,
  parameter logic [IO_ADDR_W-1:0] BASE_ADDR   = 6'h00,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IO_ADDR_W-1:0]  io_addr,
  input  logic                  io_we,
  input  logic                  io_re,
  input  logic [IO_DATA_W-1:0]  io_out,
  output logic [IO_DATA_W-1:0]  io_in,
  input  logic [PORT_WIDTH-1:0] pin_in,
  output logic [PORT_WIDTH-1:0] pin_out,
  output logic [PORT_WIDTH-1:0] pin_oe,
  output logic                  irq
);

  logic [PORT_WIDTH-1:0] dir_q;
  logic [PORT_WIDTH-1:0] out_q;
  logic [PORT_WIDTH-1:0] mask_q;
  logic [PORT_WIDTH-1:0] flags_q;
  logic [1:0]            isc_q;
  logic                  irq_q;

  logic [PORT_WIDTH-1:0] dir_n;
  logic [PORT_WIDTH-1:0] out_n;
  logic [PORT_WIDTH-1:0] mask_n;
  logic [PORT_WIDTH-1:0] flags_n;
  logic [1:0]            isc_n;

  logic [PORT_WIDTH-1:0] s;
  logic [PORT_WIDTH-1:0] rise;
  logic [PORT_WIDTH-1:0] fall;
  logic [PORT_WIDTH-1:0] ev;
  logic [PORT_WIDTH-1:0] w1c;
  logic [PORT_WIDTH-1:0] wdata;

  logic [IO_ADDR_W:0]    addr_ext;
  logic [IO_ADDR_W:0]    win_lo;
  logic [IO_ADDR_W:0]    win_hi;
  logic                  sel;
  logic                  wr;
  logic [3:0]            off;
  logic [IO_DATA_W-1:0]  rd_data;

  io_sync_edge #(
    .WIDTH  (PORT_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (pin_in),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  // Window compare is done one bit wider so a base near the top of the
  // address space cannot wrap around and alias low addresses.
  assign addr_ext = {1'b0, io_addr};
  assign win_lo   = {1'b0, BASE_ADDR};
  assign win_hi   = win_lo + (IO_ADDR_W+1)'(8);
  assign sel      = (addr_ext >= win_lo) && (addr_ext <= win_hi);
  assign off      = 4'(io_addr - BASE_ADDR);
  assign wr       = io_we & sel;
  assign wdata    = io_out[PORT_WIDTH-1:0];

  assign ev = (rise & {PORT_WIDTH{isc_q[0]}}) | (fall & {PORT_WIDTH{isc_q[1]}});

  always_comb begin
    dir_n  = dir_q;
    out_n  = out_q;
    mask_n = mask_q;
    isc_n  = isc_q;
    w1c    = '0;
    if (wr) begin
      case (off)
        GPIO_DIR:      dir_n  = wdata;
        GPIO_OUT:      out_n  = wdata;
        GPIO_OUTSET:   out_n  = out_q | wdata;
        GPIO_OUTCLR:   out_n  = out_q & ~wdata;
        GPIO_OUTTGL:   out_n  = out_q ^ wdata;
        GPIO_INTMASK:  mask_n = wdata;
        GPIO_INTFLAGS: w1c    = wdata;
        GPIO_ISC:      isc_n  = io_out[1:0];
        default: ;
      endcase
    end
    // Edge set is applied after the clear so a same-cycle edge survives W1C.
    flags_n = (flags_q & ~w1c) | ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q   <= '0;
      out_q   <= '0;
      mask_q  <= '0;
      flags_q <= '0;
      isc_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      dir_q   <= dir_n;
      out_q   <= out_n;
      mask_q  <= mask_n;
      flags_q <= flags_n;
      isc_q   <= isc_n;
      irq_q   <= |(flags_n & mask_n);
    end
  end

  always_comb begin
    rd_data = '0;
    if (io_re && sel) begin
      case (off)
        GPIO_DIR:      rd_data = IO_DATA_W'(dir_q);
        GPIO_OUT:      rd_data = IO_DATA_W'(out_q);
        GPIO_IN:       rd_data = IO_DATA_W'(s);
        GPIO_INTMASK:  rd_data = IO_DATA_W'(mask_q);
        GPIO_INTFLAGS: rd_data = IO_DATA_W'(flags_q);
        GPIO_ISC:      rd_data = IO_DATA_W'(isc_q);
        default:       rd_data = '0;
      endcase
    end
  end

  assign io_in   = rd_data;
  assign pin_out = out_q;
  assign pin_oe  = dir_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_io_gpio_port.sv
// Self-checking bench for io_gpio_port: directed scenarios with literal
// expectations, then random bus/pin traffic checked against a cycle model.
module tb_io_gpio_port;

  localparam int         PW   = 8;
  localparam int         SS   = 2;
  localparam logic [5:0] BASE = 6'h10;

  logic          clk;
  logic          rst;
  logic [5:0]    io_addr;
  logic          io_we;
  logic          io_re;
  logic [7:0]    io_out;
  logic [7:0]    io_in;
  logic [PW-1:0] pin_in;
  logic [PW-1:0] pin_out;
  logic [PW-1:0] pin_oe;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;

  io_gpio_port #(
    .PORT_WIDTH  (PW),
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (SS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io_addr (io_addr),
    .io_we   (io_we),
    .io_re   (io_re),
    .io_out  (io_out),
    .io_in   (io_in),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .pin_oe  (pin_oe),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: register contents plus a log of sampled pin values.
  logic [7:0] m_dir, m_out, m_mask, m_flags;
  logic [1:0] m_isc;
  logic [7:0] pin_log [64];
  int         cyc = 0;
  int         rst_cyc = 0;
  bit         model_ready = 0;

  // Synchronised pin value visible after edge n: the pin sampled SS-1 edges
  // earlier, unless a reset occurred at or after that sampling edge.
  function automatic logic [7:0] s_at(input int n);
    if (n - SS + 1 <= rst_cyc) return 8'h00;
    return pin_log[(n - SS + 1) % 64];
  endfunction

  function automatic logic [7:0] model_read();
    int off;
    off = int'(io_addr) - int'(BASE);
    if (!io_re || off < 0 || off > 8) return 8'h00;
    case (off)
      0: return m_dir;
      1: return m_out;
      5: return s_at(cyc);
      6: return m_mask;
      7: return m_flags;
      8: return {6'b0, m_isc};
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [7:0] s_now, s_old, ev, w1c;
    int off;
    cyc++;
    pin_log[cyc % 64] = pin_in;
    s_now = s_at(cyc - 1);
    s_old = s_at(cyc - 2);
    ev = ((s_now & ~s_old) & {8{m_isc[0]}}) | ((~s_now & s_old) & {8{m_isc[1]}});
    if (rst) begin
      m_dir = 0; m_out = 0; m_mask = 0; m_flags = 0; m_isc = 0;
      rst_cyc = cyc;
      model_ready = 1;
    end else begin
      w1c = 8'h00;
      off = int'(io_addr) - int'(BASE);
      if (io_we && off >= 0 && off <= 8) begin
        case (off)
          0: m_dir = io_out;
          1: m_out = io_out;
          2: m_out = m_out | io_out;
          3: m_out = m_out & ~io_out;
          4: m_out = m_out ^ io_out;
          6: m_mask = io_out;
          7: w1c = io_out;
          8: m_isc = io_out[1:0];
          default: ;
        endcase
      end
      m_flags = (m_flags & ~w1c) | ev;
    end
  end

  task automatic check_output(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      check_output("pin_out", pin_out, m_out);
      check_output("pin_oe", pin_oe, m_dir);
      check_output("irq", {7'b0, irq}, {7'b0, |(m_flags & m_mask)});
      check_output("io_in", io_in, model_read());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [5:0] a, input logic [7:0] d);
    io_addr = a; io_out = d; io_we = 1'b1;
    tick();
    io_we = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [5:0] a, input logic [7:0] exp);
    io_addr = a; io_re = 1'b1;
    #1;
    check_output(name, io_in, exp);
    io_re = 1'b0;
  endtask

  initial begin
    rst = 1'b1; io_addr = 6'h00; io_we = 1'b0; io_re = 1'b0;
    io_out = 8'h00; pin_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    $display("[TB] reset state");
    read_expect("rst_dir", BASE + 6'd0, 8'h00);
    read_expect("rst_out", BASE + 6'd1, 8'h00);
    read_expect("rst_flags", BASE + 6'd7, 8'h00);
    check_output("rst_pin_oe", pin_oe, 8'h00);
    check_output("rst_pin_out", pin_out, 8'h00);
    check_output("rst_irq", {7'b0, irq}, 8'h00);

    $display("[TB] output strobes");
    apply_stimulus(BASE + 6'd0, 8'hFF);
    apply_stimulus(BASE + 6'd1, 8'h0F);
    apply_stimulus(BASE + 6'd2, 8'h30);
    check_output("outset", pin_out, 8'h3F);
    apply_stimulus(BASE + 6'd3, 8'h03);
    check_output("outclr", pin_out, 8'h3C);
    apply_stimulus(BASE + 6'd4, 8'hFF);
    check_output("outtgl", pin_out, 8'hC3);
    check_output("dir_ff", pin_oe, 8'hFF);
    read_expect("read_outset", BASE + 6'd2, 8'h00);

    $display("[TB] input sync and decode");
    pin_in = 8'hA5;
    read_expect("in_early0", BASE + 6'd5, 8'h00);
    repeat (SS - 1) tick();
    read_expect("in_early", BASE + 6'd5, 8'h00);
    tick();
    read_expect("in_sync", BASE + 6'd5, 8'hA5);
    read_expect("out_of_range_hi", 6'h19, 8'h00);
    read_expect("out_of_range_lo", 6'h0F, 8'h00);

    $display("[TB] rising-edge interrupt");
    pin_in = 8'h00;
    repeat (4) tick();
    apply_stimulus(BASE + 6'd8, 8'h01);
    apply_stimulus(BASE + 6'd6, 8'h01);
    pin_in = 8'h01;
    repeat (SS) tick();
    check_output("irq_not_yet", {7'b0, irq}, 8'h00);
    tick();
    check_output("irq_rise", {7'b0, irq}, 8'h01);
    read_expect("flags_rise", BASE + 6'd7, 8'h01);
    pin_in = 8'h00;
    repeat (4) tick();
    read_expect("flags_no_fall", BASE + 6'd7, 8'h01);
    apply_stimulus(BASE + 6'd7, 8'h01);
    check_output("irq_w1c", {7'b0, irq}, 8'h00);
    read_expect("flags_w1c", BASE + 6'd7, 8'h00);

    $display("[TB] W1C/edge collision");
    apply_stimulus(BASE + 6'd8, 8'hFF);
    read_expect("isc_bits", BASE + 6'd8, 8'h03);
    pin_in = 8'h04;
    repeat (SS) tick();
    apply_stimulus(BASE + 6'd7, 8'h04);
    read_expect("flags_collide", BASE + 6'd7, 8'h04);
    apply_stimulus(BASE + 6'd7, 8'h04);
    read_expect("flags_cleared", BASE + 6'd7, 8'h00);

    $display("[TB] reset mid-operation");
    apply_stimulus(BASE + 6'd0, 8'hFF);
    apply_stimulus(BASE + 6'd1, 8'h55);
    pin_in = 8'h05;
    repeat (SS + 1) tick();
    read_expect("flags_pre_rst", BASE + 6'd7, 8'h01);
    check_output("irq_pre_rst", {7'b0, irq}, 8'h01);
    rst = 1'b1; io_addr = BASE + 6'd2; io_out = 8'hAA; io_we = 1'b1;
    tick();
    rst = 1'b0; io_we = 1'b0;
    check_output("rst_mid_pin_out", pin_out, 8'h00);
    check_output("rst_mid_pin_oe", pin_oe, 8'h00);
    check_output("rst_mid_irq", {7'b0, irq}, 8'h00);
    read_expect("rst_mid_dir", BASE + 6'd0, 8'h00);
    read_expect("rst_mid_out", BASE + 6'd1, 8'h00);
    read_expect("rst_mid_flags", BASE + 6'd7, 8'h00);
    read_expect("rst_mid_isc", BASE + 6'd8, 8'h00);
    repeat (SS + 2) tick();
    read_expect("no_flags_after_rst", BASE + 6'd7, 8'h00);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 249) == 0);
      io_we   = ($urandom_range(0, 2) == 0);
      io_re   = $urandom_range(0, 1) == 1;
      io_addr = 6'($urandom_range(12, 27));
      io_out  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) pin_in = PW'($urandom);
      tick();
    end
    rst = 1'b0; io_we = 1'b0; io_re = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
